// File: rtl/edge_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_meter_pkg
//  Description : Shared types and default constants for the edge pulse meter.
//                Holds the phase state enum, the measurement record layout
//                and the default counter / total widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package edge_meter_pkg;

    // Default widths of the phase-length counter and of the edge totals.
    localparam int CNT_W_DEF   = 16;
    localparam int TOT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

    // Phase tracking state. IDLE means no phase reference has been seen yet.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    // Measurement record at the default counter width. The top level builds
    // the same {level, sat, count} layout at its own CNT_W.
    typedef struct packed {
        logic                 level;
        logic                 sat;
        logic [CNT_W_DEF-1:0] count;
    } meas_t;

endpackage : edge_meter_pkg
`default_nettype wire

// File: rtl/edge_meter_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : edge_meter_out_slot
//  Description : One-entry valid/ready holding register. A push is accepted
//                when the slot is empty or is being drained in the same
//                cycle; otherwise it is refused and the parent decides what a
//                refusal means. Held data is frozen while valid and not ready.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push, i_data  - new entry offered by the parent
//                i_ready         - consumer accepts the held entry
//                o_valid, o_data - held entry
//                o_accept        - push taken this cycle (push & !o_accept
//                                  is a drop)
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_meter_out_slot
    import edge_meter_pkg::*;
#(
    parameter int W = $bits(meas_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_accept
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Drain and reload in the same cycle keeps back-to-back traffic lossless.
    assign o_accept = i_push && (!r_valid || i_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_accept) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : edge_meter_out_slot
`default_nettype wire

// File: rtl/edge_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_pulse_meter
//  Description : Measures the length in clock cycles of each high and low
//                phase of a monitored signal, from the single-cycle rising /
//                falling pulses of an upstream edge detector. Each completed
//                phase is offered as one measurement over valid/ready.
//                Running rise/fall totals are kept alongside.
//  Ports       : clock, reset               - clock, sync active-high reset
//                risingEdge, fallingEdge    - edge pulses
//                meas_ready                 - consumer ready
//                meas_valid/level/count/sat - held measurement
//                overrun, edge_err          - sticky error flags
//                timeout_pulse              - one-cycle phase timeout
//                rise_total, fall_total     - wrapping edge totals
//  Config      : define EDGE_METER_TIMEOUT_EN to abandon a phase that lasts
//                TIMEOUT cycles without an edge. Undefined: no timeout logic,
//                timeout_pulse tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse_meter
    import edge_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TOT_W   = TOT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             risingEdge,
    input  logic             fallingEdge,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic             meas_level,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_sat,
    output logic             overrun,
    output logic             edge_err,
    output logic             timeout_pulse,
    output logic [TOT_W-1:0] rise_total,
    output logic [TOT_W-1:0] fall_total
);

    // Measurement record at this instance's counter width.
    typedef struct packed {
        logic             level;
        logic             sat;
        logic [CNT_W-1:0] count;
    } meas_p_t;

    localparam int               c_MEAS_W  = $bits(meas_p_t);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // A timeout that the counter can never reach would silently disable it.
    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_timeout_range
        $error("edge_pulse_meter: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    // ------------------------------------------------------------------
    // Edge qualification: simultaneous pulses are contradictory and are
    // treated as no event (only edge_err records them).
    // ------------------------------------------------------------------
    logic w_rise;
    logic w_fall;
    logic w_both;

    assign w_rise = risingEdge  && !fallingEdge;
    assign w_fall = fallingEdge && !risingEdge;
    assign w_both = risingEdge  &&  fallingEdge;

    // ------------------------------------------------------------------
    // Phase counter and state
    // ------------------------------------------------------------------
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_in_phase;
    logic             w_timeout;

    assign w_in_phase = (r_state == ST_HIGH) || (r_state == ST_LOW);

`ifdef EDGE_METER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    // A real edge in the timeout cycle wins and is handled normally.
    assign w_timeout = w_in_phase && !w_rise && !w_fall && (r_cnt == c_TIMEOUT);
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A repeated edge of the current polarity restarts
    // the phase, which is the same target state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_state_nxt = ST_LOW;
                end else if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output / control decode
    logic w_push;
    logic w_push_level;
    logic w_load_one;
    logic w_inc;

    always_comb begin
        w_push       = 1'b0;
        w_push_level = 1'b0;
        // Every qualified edge starts a new phase count, whatever the state.
        w_load_one   = w_rise || w_fall;
        w_inc        = w_in_phase && !w_rise && !w_fall && !w_timeout;
        case (r_state)
            ST_HIGH: begin
                w_push       = w_fall;
                w_push_level = 1'b1;
            end
            ST_LOW: begin
                w_push       = w_rise;
                w_push_level = 1'b0;
            end
            default: begin
                w_push       = 1'b0;
                w_push_level = 1'b0;
            end
        endcase
    end

    // Counter with saturation flag. r_cnt equals the number of cycles since
    // the phase-opening edge, so on the closing edge it is the phase length.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_load_one) begin
            r_cnt <= CNT_W'(1);
            r_sat <= 1'b0;
        end else if (w_timeout) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_inc) begin
            if (r_cnt == c_CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    meas_p_t w_meas_in;
    meas_p_t w_meas_out;
    logic    w_slot_valid;
    logic    w_accept;

    assign w_meas_in.level = w_push_level;
    assign w_meas_in.sat   = r_sat;
    assign w_meas_in.count = r_cnt;

    edge_meter_out_slot #(
        .W (c_MEAS_W)
    ) u_out_slot (
        .clk      (clock),
        .rst      (reset),
        .i_push   (w_push),
        .i_data   (w_meas_in),
        .i_ready  (meas_ready),
        .o_valid  (w_slot_valid),
        .o_data   (w_meas_out),
        .o_accept (w_accept)
    );

    assign meas_valid = w_slot_valid;
    assign meas_level = w_meas_out.level;
    assign meas_sat   = w_meas_out.sat;
    assign meas_count = w_meas_out.count;

    // ------------------------------------------------------------------
    // Sticky flags, timeout pulse and totals
    // ------------------------------------------------------------------
    logic             r_overrun;
    logic             r_edge_err;
    logic             r_timeout;
    logic [TOT_W-1:0] r_rise_total;
    logic [TOT_W-1:0] r_fall_total;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun    <= 1'b0;
            r_edge_err   <= 1'b0;
            r_timeout    <= 1'b0;
            r_rise_total <= '0;
            r_fall_total <= '0;
        end else begin
            if (w_push && !w_accept) begin
                r_overrun <= 1'b1;
            end
            if (w_both) begin
                r_edge_err <= 1'b1;
            end
            r_timeout <= w_timeout;
            if (w_rise) begin
                r_rise_total <= r_rise_total + TOT_W'(1);
            end
            if (w_fall) begin
                r_fall_total <= r_fall_total + TOT_W'(1);
            end
        end
    end

    assign overrun       = r_overrun;
    assign edge_err      = r_edge_err;
    assign timeout_pulse = r_timeout;
    assign rise_total    = r_rise_total;
    assign fall_total    = r_fall_total;

endmodule : edge_pulse_meter
`default_nettype wire

// File: tb/tb_edge_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_pulse_meter
//  Description : Self-checking bench for edge_pulse_meter (CNT_W=4,
//                TIMEOUT=8). Expected measurements are queued when the
//                closing edge is driven and compared on each transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_pulse_meter;

    localparam int CW = 4;
    localparam int TW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          risingEdge;
    logic          fallingEdge;
    logic          meas_ready;
    logic          meas_valid;
    logic          meas_level;
    logic [CW-1:0] meas_count;
    logic          meas_sat;
    logic          overrun;
    logic          edge_err;
    logic          timeout_pulse;
    logic [TW-1:0] rise_total;
    logic [TW-1:0] fall_total;

    edge_pulse_meter #(
        .CNT_W   (CW),
        .TOT_W   (TW),
        .TIMEOUT (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .risingEdge    (risingEdge),
        .fallingEdge   (fallingEdge),
        .meas_ready    (meas_ready),
        .meas_valid    (meas_valid),
        .meas_level    (meas_level),
        .meas_count    (meas_count),
        .meas_sat      (meas_sat),
        .overrun       (overrun),
        .edge_err      (edge_err),
        .timeout_pulse (timeout_pulse),
        .rise_total    (rise_total),
        .fall_total    (fall_total)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          level;
        logic          sat;
        logic [CW-1:0] count;
    } exp_t;

    typedef struct packed {
        logic          rise;
        logic          fall;
        logic          push;
        logic          level;
        logic [CW-1:0] count;
    } vec_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every transfer must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && meas_valid && meas_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas: got level=%0d count=%0d sat=%0d expected none (t=%0t)",
                         meas_level, meas_count, meas_sat, $time);
            end else begin
                e = q.pop_front();
                pops++;
                chk("meas_level", 32'(meas_level), 32'(e.level));
                chk("meas_count", 32'(meas_count), 32'(e.count));
                chk("meas_sat",   32'(meas_sat),   32'(e.sat));
            end
        end
    end

    task automatic step(input logic r, input logic f);
        risingEdge  = r;
        fallingEdge = f;
        @(posedge clock);
        #1;
        risingEdge  = 1'b0;
        fallingEdge = 1'b0;
    endtask

    task automatic expect_meas(input logic lvl, input logic [CW-1:0] cnt, input logic sat);
        exp_t x;
        x.level = lvl;
        x.count = cnt;
        x.sat   = sat;
        q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   32'(meas_valid),    32'd0);
        chk({tag, "_level"},   32'(meas_level),    32'd0);
        chk({tag, "_count"},   32'(meas_count),    32'd0);
        chk({tag, "_sat"},     32'(meas_sat),      32'd0);
        chk({tag, "_flags"},   {29'd0, overrun, edge_err, timeout_pulse}, 32'd0);
        chk({tag, "_totals"},  {rise_total, fall_total}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        reset       = 1'b1;
        risingEdge  = 1'b0;
        fallingEdge = 1'b0;
        meas_ready  = 1'b1;

        // Alternating edges every cycle: first opens a phase, the rest close one.
        vecs[0] = '{rise:1'b1, fall:1'b0, push:1'b0, level:1'b0, count:4'd0};
        vecs[1] = '{rise:1'b0, fall:1'b1, push:1'b1, level:1'b1, count:4'd1};
        vecs[2] = '{rise:1'b1, fall:1'b0, push:1'b1, level:1'b0, count:4'd1};
        vecs[3] = '{rise:1'b0, fall:1'b1, push:1'b1, level:1'b1, count:4'd1};
        vecs[4] = '{rise:1'b1, fall:1'b0, push:1'b1, level:1'b0, count:4'd1};
        vecs[5] = '{rise:1'b0, fall:1'b1, push:1'b1, level:1'b1, count:4'd1};
        vecs[6] = '{rise:1'b1, fall:1'b0, push:1'b1, level:1'b0, count:4'd1};
        vecs[7] = '{rise:1'b0, fall:1'b1, push:1'b1, level:1'b1, count:4'd1};

        // ---- Reset state and a basic 5-cycle high phase ----
        do_reset();
        chk_all_zero("reset");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("no_meas_mid_phase", 32'(meas_valid), 32'd0);
        expect_meas(1'b1, 4'd5, 1'b0);
        step(1'b0, 1'b1);
        chk("t1_valid", 32'(meas_valid), 32'd1);
        chk("t1_count", 32'(meas_count), 32'd5);
        chk("t1_level", 32'(meas_level), 32'd1);
        chk("t1_rise_total", 32'(rise_total), 32'd1);
        chk("t1_fall_total", 32'(fall_total), 32'd1);
        step(1'b0, 1'b0);
        chk("t1_valid_drop", 32'(meas_valid), 32'd0);

        // ---- Back-to-back minimum phases ----
        do_reset();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].push) expect_meas(vecs[i].level, vecs[i].count, 1'b0);
            step(vecs[i].rise, vecs[i].fall);
            chk("b2b_valid", 32'(meas_valid), 32'(vecs[i].push));
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("b2b_pops", 32'(pops), 32'd7);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_totals", {rise_total, fall_total}, {16'd4, 16'd4});

        // ---- Held measurement under backpressure, second one dropped ----
        meas_ready = 1'b0;
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        expect_meas(1'b1, 4'd3, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("hold_count", 32'(meas_count), 32'd3);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("hold_valid", 32'(meas_valid), 32'd1);
        chk("hold_count_after_drop", 32'(meas_count), 32'd3);
        chk("hold_level_after_drop", 32'(meas_level), 32'd1);
        chk("overrun_set", 32'(overrun), 32'd1);
        meas_ready = 1'b1;
        pops = 0;
        step(1'b0, 1'b0);
        chk("hold_drained", 32'(pops), 32'd1);
        chk("hold_valid_clear", 32'(meas_valid), 32'd0);
        step(1'b0, 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // ---- Both edges at once while HIGH ----
        do_reset();
        chk("overrun_cleared", 32'(overrun), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("both_edge_err", 32'(edge_err), 32'd1);
        chk("both_totals", {rise_total, fall_total}, {16'd1, 16'd0});
        chk("both_no_meas", 32'(meas_valid), 32'd0);
        step(1'b0, 1'b0);
        expect_meas(1'b1, 4'd5, 1'b0);
        step(1'b0, 1'b1);
        chk("both_meas_valid", 32'(meas_valid), 32'd1);
        step(1'b0, 1'b0);
        chk("edge_err_sticky", 32'(edge_err), 32'd1);

        // ---- Long high phase: saturation or timeout ----
        do_reset();
        step(1'b1, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            step(1'b0, 1'b0);
`ifdef EDGE_METER_TIMEOUT_EN
            chk("timeout_pulse", 32'(timeout_pulse), 32'(k == 8));
`else
            chk("timeout_tied0", 32'(timeout_pulse), 32'd0);
`endif
        end
`ifdef EDGE_METER_TIMEOUT_EN
        step(1'b0, 1'b1);
        chk("timeout_no_meas", 32'(meas_valid), 32'd0);
`else
        expect_meas(1'b1, 4'd15, 1'b1);
        step(1'b0, 1'b1);
        chk("sat_valid", 32'(meas_valid), 32'd1);
        chk("sat_count", 32'(meas_count), 32'd15);
        chk("sat_flag", 32'(meas_sat), 32'd1);
`endif
        step(1'b0, 1'b0);

        // ---- Reset mid-phase ----
        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0);
        chk_all_zero("midreset");
        reset = 1'b0;
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("midreset_no_meas", 32'(meas_valid), 32'd0);
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_edge_pulse_meter
`default_nettype wire
